// File: rtl/irq_dispatcher.sv
// Interrupt dispatcher: reads ACTIVE from the controller, masks the lowest active
// line in ENABLED, offers its vector to the core, and restores ENABLED on EOI.
module irq_dispatcher #(
    parameter int IRQ_COUNT  = 32,
    parameter int SPURIOUS_W = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  interrupt_i,
    output logic                  chip_select_o,
    output logic [3:0]            addr_o,
    output logic                  read_enable_o,
    input  logic [31:0]           read_data_i,
    output logic [31:0]           write_data_o,
    output logic [3:0]            write_mask_o,
    output logic                  vector_valid_o,
    output logic [4:0]            vector_o,
    input  logic                  vector_ready_i,
    input  logic                  eoi_i,
    output logic                  busy_o,
    output logic [SPURIOUS_W-1:0] spurious_o
);

    localparam logic [31:0] IRQ_MASK = (IRQ_COUNT >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << IRQ_COUNT) - 32'd1);
    localparam logic [3:0]  ADDR_ENABLED = 4'd1;
    localparam logic [3:0]  ADDR_ACTIVE  = 4'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_ACT,
        S_CAP_ACT,
        S_RD_EN,
        S_CAP_EN,
        S_WR_MASK,
        S_OFFER,
        S_SERVICE,
        S_WR_RESTORE
    } state_e;

    state_e                state_q, state_d;
    logic [4:0]            vec_q, vec_d;
    logic [31:0]           en_saved_q, en_saved_d;
    logic [SPURIOUS_W-1:0] spurious_q, spurious_d;
    logic [31:0]           act;

    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i[4:0];
        end
        return idx;
    endfunction

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            en_saved_q <= '0;
            spurious_q <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            en_saved_q <= en_saved_d;
            spurious_q <= spurious_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        en_saved_d = en_saved_q;
        spurious_d = spurious_q;
        act        = read_data_i & IRQ_MASK;
        case (state_q)
            S_IDLE:       if (interrupt_i) state_d = S_RD_ACT;
            S_RD_ACT:     state_d = S_CAP_ACT;
            S_CAP_ACT: begin
                if (act == '0) begin
                    if (spurious_q != '1) spurious_d = spurious_q + SPURIOUS_W'(1);
                    state_d = S_IDLE;
                end else begin
                    vec_d   = lowest_set(act);
                    state_d = S_RD_EN;
                end
            end
            S_RD_EN:      state_d = S_CAP_EN;
            S_CAP_EN: begin
                en_saved_d = read_data_i;
                state_d    = S_WR_MASK;
            end
            S_WR_MASK:    state_d = S_OFFER;
            S_OFFER:      if (vector_ready_i) state_d = S_SERVICE;
            S_SERVICE:    if (eoi_i) state_d = S_WR_RESTORE;
            S_WR_RESTORE: state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Bus and handshake outputs depend on the state register only.
    always_comb begin
        chip_select_o  = 1'b0;
        addr_o         = '0;
        read_enable_o  = 1'b0;
        write_data_o   = '0;
        write_mask_o   = '0;
        vector_valid_o = 1'b0;
        case (state_q)
            S_RD_ACT: begin
                chip_select_o = 1'b1;
                addr_o        = ADDR_ACTIVE;
                read_enable_o = 1'b1;
            end
            S_RD_EN: begin
                chip_select_o = 1'b1;
                addr_o        = ADDR_ENABLED;
                read_enable_o = 1'b1;
            end
            S_WR_MASK: begin
                chip_select_o = 1'b1;
                addr_o        = ADDR_ENABLED;
                write_mask_o  = 4'hF;
                write_data_o  = en_saved_q & ~(32'd1 << vec_q);
            end
            S_OFFER:      vector_valid_o = 1'b1;
            S_WR_RESTORE: begin
                chip_select_o = 1'b1;
                addr_o        = ADDR_ENABLED;
                write_mask_o  = 4'hF;
                write_data_o  = en_saved_q;
            end
            default: ;
        endcase
    end

    assign vector_o   = vec_q;
    assign busy_o     = (state_q != S_IDLE);
    assign spurious_o = spurious_q;

endmodule

// File: tb/tb_irq_dispatcher.sv
// Bench for irq_dispatcher: a register-level controller model answers the bus, and
// each dispatch is predicted from PENDING/ENABLED as a list of bus accesses.
module tb_irq_dispatcher;

    localparam int SPW    = 8;
    localparam int SP_MAX = (1 << SPW) - 1;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    logic interrupt_i = 1'b0;
    logic vector_ready_i = 1'b0;
    logic eoi_i = 1'b0;
    logic [31:0] rd = '0;

    logic cs32, re32, vld32, busy32;
    logic [3:0] addr32, wm32;
    logic [31:0] wd32;
    logic [4:0] vec32;
    logic [SPW-1:0] spc32;

    logic cs16, re16, vld16, busy16;
    logic [3:0] addr16, wm16;
    logic [31:0] wd16;
    logic [4:0] vec16;
    logic [SPW-1:0] spc16;

    irq_dispatcher #(.IRQ_COUNT(32), .SPURIOUS_W(SPW)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .interrupt_i(interrupt_i),
        .chip_select_o(cs32), .addr_o(addr32), .read_enable_o(re32),
        .read_data_i(rd), .write_data_o(wd32), .write_mask_o(wm32),
        .vector_valid_o(vld32), .vector_o(vec32), .vector_ready_i(vector_ready_i),
        .eoi_i(eoi_i), .busy_o(busy32), .spurious_o(spc32)
    );

    // Narrow instance shares the read data of the main instance's bus.
    irq_dispatcher #(.IRQ_COUNT(16), .SPURIOUS_W(SPW)) dut16 (
        .clk_i(clk), .reset_ni(reset_ni), .interrupt_i(interrupt_i),
        .chip_select_o(cs16), .addr_o(addr16), .read_enable_o(re16),
        .read_data_i(rd), .write_data_o(wd16), .write_mask_o(wm16),
        .vector_valid_o(vld16), .vector_o(vec16), .vector_ready_i(vector_ready_i),
        .eoi_i(eoi_i), .busy_o(busy16), .spurious_o(spc16)
    );

    always #5 clk = ~clk;

    // Controller model and bus access log
    logic [31:0] pend_m = '0;
    logic [31:0] enab_m = '0;
    logic        en_load = 1'b0;
    logic [31:0] en_init = '0;
    int          log_n = 0;
    logic [8:0]  log_ctl [0:1023];
    logic [31:0] log_wd  [0:1023];

    always @(posedge clk) begin
        if (en_load) enab_m <= en_init;
        else if (cs32 && !re32 && wm32 == 4'hF && addr32 == 4'd1) enab_m <= wd32;
        if (cs32 && re32) begin
            case (addr32)
                4'd0:    rd <= pend_m;
                4'd1:    rd <= enab_m;
                4'd2:    rd <= pend_m & enab_m;
                default: rd <= '0;
            endcase
        end else begin
            rd <= '0;
        end
        if (cs32) begin
            log_ctl[log_n % 1024] <= {addr32, re32, wm32};
            log_wd[log_n % 1024]  <= wd32;
            log_n <= log_n + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int sp32 = 0;
    int sp16 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic load(input logic [31:0] pend, input logic [31:0] en);
        pend_m  = pend;
        en_init = en;
        en_load = 1'b1;
        step();
        en_load = 1'b0;
    endtask

    task automatic check_entry(input string tag, input int idx, input logic [8:0] ctl,
                               input logic [31:0] wd);
        check({tag, "_ctl"}, 32'(log_ctl[idx % 1024]), 32'(ctl));
        check({tag, "_wd"}, log_wd[idx % 1024], wd);
    endtask

    task automatic dispatch(input logic [31:0] pend, input logic [31:0] en,
                            input int rdy_wait, input bit early_eoi, input int svc_wait);
        logic [31:0] act32, act16, masked;
        int v32, k, base;
        bit seen;
        act32  = pend & en;
        act16  = act32 & 32'h0000_FFFF;
        v32    = lowest(act32);
        masked = en & ~(32'd1 << v32);
        load(pend, en);
        base = log_n;
        interrupt_i = 1'b1;
        step();
        interrupt_i = 1'b0;
        if (act16 == 0 && sp16 < SP_MAX) sp16++;
        if (act32 == 0) begin
            if (sp32 < SP_MAX) sp32++;
            k = 0;
            seen = 1'b0;
            while (busy32 && k < 10) begin
                step();
                k++;
                if (vld32) seen = 1'b1;
            end
            check("spur_idle_lat", 32'(k), 32'd2);
            check("spur_no_valid", 32'(seen), 32'd0);
            check("spur_cnt", 32'(spc32), 32'(sp32));
            check("spur_cnt16", 32'(spc16), 32'(sp16));
            check("spur_accesses", 32'(log_n - base), 32'd1);
            check_entry("spur_rd_act", base, {4'd2, 1'b1, 4'h0}, 32'h0);
            check("spur_en_kept", enab_m, en);
            return;
        end
        k = 0;
        while (!vld32 && k < 12) begin
            step();
            k++;
        end
        check("offer_latency", 32'(k), 32'd5);
        check("offer_vector", 32'(vec32), 32'(v32));
        check("offer_en_masked", enab_m, masked);
        if (act16 != 0) begin
            check("offer_vld16", 32'(vld16), 32'd1);
            check("offer_vec16", 32'(vec16), 32'(v32));
        end else begin
            check("narrow_idle", 32'({vld16, busy16}), 32'd0);
            check("narrow_spur", 32'(spc16), 32'(sp16));
        end
        for (int i = 0; i < rdy_wait; i++) begin
            if (early_eoi && i == 0) eoi_i = 1'b1;
            step();
            eoi_i = 1'b0;
            check("hold_valid", 32'(vld32), 32'd1);
            check("hold_vector", 32'(vec32), 32'(v32));
        end
        vector_ready_i = 1'b1;
        step();
        vector_ready_i = 1'b0;
        check("svc_entry", 32'({busy32, vld32, cs32}), 32'b100);
        for (int i = 0; i < svc_wait; i++) begin
            step();
            check("svc_quiet", 32'({busy32, vld32, cs32}), 32'b100);
        end
        eoi_i = 1'b1;
        step();
        eoi_i = 1'b0;
        check("restore_ctl", 32'({cs32, addr32, re32, wm32}), 32'({1'b1, 4'd1, 1'b0, 4'hF}));
        check("restore_wd", wd32, en);
        step();
        check("back_idle", 32'(busy32), 32'd0);
        check("en_restored", enab_m, en);
        check("accesses", 32'(log_n - base), 32'd4);
        check_entry("rd_act", base,     {4'd2, 1'b1, 4'h0}, 32'h0);
        check_entry("rd_en",  base + 1, {4'd1, 1'b1, 4'h0}, 32'h0);
        check_entry("wr_msk", base + 2, {4'd1, 1'b0, 4'hF}, masked);
        check_entry("wr_rst", base + 3, {4'd1, 1'b0, 4'hF}, en);
        check("spur_unchanged", 32'(spc32), 32'(sp32));
    endtask

    initial begin
        int k, rw;
        logic [31:0] p, e;
        bit eb;

        // Reset state
        #1;
        check("rst_outs", 32'({cs32, addr32, re32, wm32, vld32, vec32, busy32}), 32'h0);
        check("rst_wd", wd32, 32'h0);
        check("rst_spur", 32'(spc32), 32'h0);
        step();
        step();
        reset_ni = 1'b1;
        step();

        // Reset while the vector is on offer
        load(32'h30, 32'h30);
        interrupt_i = 1'b1;
        step();
        interrupt_i = 1'b0;
        k = 0;
        while (!vld32 && k < 12) begin
            step();
            k++;
        end
        check("pre_rst_offer", 32'(vld32), 32'd1);
        reset_ni = 1'b0;
        #1;
        check("midrst_outs", 32'({cs32, addr32, re32, wm32, vld32, vec32, busy32}), 32'h0);
        check("midrst_wd", wd32, 32'h0);
        check("midrst_spur", 32'(spc32), 32'h0);
        check("midrst_still_masked", enab_m, 32'h20);
        step();
        reset_ni = 1'b1;
        sp32 = 0;
        sp16 = 0;
        step();
        check("post_rst_idle", 32'(busy32), 32'd0);

        // Lines 4 and 5 pending and enabled
        dispatch(32'h30, 32'h30, 0, 1'b0, 2);
        // Spurious, then saturation
        dispatch(32'h0, 32'h30, 0, 1'b0, 0);
        for (int i = 0; i < (1 << SPW) + 3; i++) dispatch(32'h0, 32'hFFFF_FFFF, 0, 1'b0, 0);
        check("spur_saturated", 32'(spc32), 32'(SP_MAX));
        // Core stalls ready for 10 cycles
        dispatch(32'h30, 32'h30, 10, 1'b0, 1);
        // Width boundary
        dispatch(32'h8000_0001, 32'hFFFF_FFFF, 1, 1'b0, 0);
        dispatch(32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0, 0);
        // EOI during OFFER is ignored
        dispatch(32'h30, 32'h30, 3, 1'b1, 2);

        for (int it = 0; it < 40; it++) begin
            p = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom & $urandom);
            if ($urandom_range(0, 3) == 0) p = p & 32'hFFFF_0000;
            e  = $urandom | $urandom;
            rw = int'($urandom_range(0, 4));
            eb = (rw > 0) && ($urandom_range(0, 1) == 1);
            dispatch(p, e, rw, eb, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
